// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive port: FSM states, status bit positions
// and the status-count saturation helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned ST_AVAIL = 0;
    localparam int unsigned ST_OVR   = 1;
    localparam int unsigned ST_FERR  = 2;
    localparam int unsigned ST_BUSY  = 3;

    // The status byte only has a 4-bit count field.
    function automatic logic [3:0] sat_count(input logic [7:0] cnt);
        return (cnt > 8'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Fall-through FIFO: head always holds the oldest entry (zero when empty);
// head, count, full and empty are all registered.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count + CW'(do_push) - CW'(do_pop);
        head_d   = '0;
        // A push into a FIFO that is (or drains to) empty becomes the head directly.
        if (do_push && (count == CW'(do_pop)))
            head_d = wr_data;
        else if (count_d != '0)
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            head     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count    <= count_d;
            full     <= (count_d == CW'(DEPTH));
            empty    <= (count_d == '0);
            head     <= head_d;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver feeding a fall-through byte FIFO; the CPU polls in_status,
// reads in_data and pops the head with a one-cycle rd_ack pulse.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] in_data,
    output logic [7:0] in_status
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta, rxs, rxs_d;
    logic             busy_q, ovr_q, ovr_d, ferr_q, ferr_d;
    logic             push_c, ovr_set, ferr_set;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;

    // Two-stage synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_c   = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    push_c   = rxs;
                    ferr_set = !rxs;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop in the same cycle makes room, so only an unacknowledged full push overruns.
        ovr_set = push_c && fifo_full && !rd_ack;
        ovr_d   = ovr_set || (ovr_q && !rd_ack);
        ferr_d  = ferr_set || (ferr_q && !rd_ack);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= (state_d != IDLE);
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push_c),
        .pop     (rd_ack),
        .wr_data (shift_q),
        .head    (in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Status byte is pure wiring of registered state plus the count clamp.
    always_comb begin
        in_status           = '0;
        in_status[ST_AVAIL] = !fifo_empty;
        in_status[ST_OVR]   = ovr_q;
        in_status[ST_FERR]  = ferr_q;
        in_status[ST_BUSY]  = busy_q;
        in_status[7:4]      = sat_count(8'(fifo_count));
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: a queue/flag model driven by scheduled frame events,
// compared every cycle, plus hand-computed literal expectations.
module tb_uart_rx_port;
    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 4;
    // rx falling edge to stop-sample edge: sync + edge detect, half bit, 8 data bits, stop bit
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;
    localparam int NEV = 4096;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       rx     = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] in_data;
    logic [7:0] in_status;

    uart_rx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_ack    (rd_ack),
        .in_data   (in_data),
        .in_status (in_status)
    );

    always #5 clk = ~clk;

    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    bit         cmp_en = 1'b1;
    bit         ev_on   [NEV];
    bit         ev_off  [NEV];
    bit         ev_push [NEV];
    bit         ev_ferr [NEV];
    logic [7:0] ev_byte [NEV];
    logic [7:0] mq[$];
    bit         m_busy, m_ovr, m_ferr;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_data();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_status();
        int n;
        logic [7:0] s;
        n    = mq.size();
        s    = 8'h00;
        s[0] = (n != 0);
        s[1] = m_ovr;
        s[2] = m_ferr;
        s[3] = m_busy;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_busy = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        for (int i = cyc; i < NEV; i++) begin
            ev_on[i]   = 1'b0;
            ev_off[i]  = 1'b0;
            ev_push[i] = 1'b0;
            ev_ferr[i] = 1'b0;
        end
    endtask

    // Model update at every active edge: pop and clear on rd_ack, then push/overrun, then errors.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            model_clear();
        end else if (cyc < NEV) begin
            if (ev_on[cyc])  m_busy = 1'b1;
            if (ev_off[cyc]) m_busy = 1'b0;
            if (rd_ack) begin
                if (mq.size() != 0) void'(mq.pop_front());
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            if (ev_push[cyc]) begin
                if (mq.size() < DEPTH) mq.push_back(ev_byte[cyc]);
                else m_ovr = 1'b1;
            end
            if (ev_ferr[cyc]) m_ferr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_in_data", in_data, exp_data());
            check("cyc_in_status", in_status, exp_status());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit ack_stop);
        int c0;
        c0 = cyc;
        ev_on[c0 + 3]    = 1'b1;
        ev_off[c0 + LAT] = 1'b1;
        if (stop_v) begin
            ev_push[c0 + LAT] = 1'b1;
            ev_byte[c0 + LAT] = b;
        end else begin
            ev_ferr[c0 + LAT] = 1'b1;
        end
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_v;
        for (int k = 0; k < int'(CPB); k++) begin
            rd_ack = ack_stop && (cyc == c0 + LAT - 1);
            tick();
        end
        rd_ack = 1'b0;
        rx     = 1'b1;
        repeat (2) tick();
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        int c0;
        // 1: reset held while rx toggles
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rx = ~rx;
        end
        rx = 1'b1;
        check("t1_rst_data", in_data, 8'h00);
        check("t1_rst_status", in_status, 8'h00);
        tick();
        reset = 1'b1;
        repeat (3) tick();

        // 2: single byte, then pop
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t2_data", in_data, 8'hA5);
        check("t2_status", in_status, 8'h11);
        pulse_ack();
        check("t2_pop_data", in_data, 8'h00);
        check("t2_pop_status", in_status, 8'h00);

        // 3: five bytes into a four-deep FIFO
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0);
        check("t3_status", in_status, 8'h43);
        for (int i = 0; i < 4; i++) begin
            check("t3_head", in_data, 8'(i + 1));
            pulse_ack();
            if (i == 0) check("t3_ovr_clear", in_status, 8'h31);
        end
        check("t3_drained", in_status, 8'h00);

        // 4: stop bit low -> framing error, nothing stored
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t4_status", in_status, 8'h04);
        check("t4_data", in_data, 8'h00);
        pulse_ack();
        check("t4_clear", in_status, 8'h00);

        // 5: two-clock low glitch is rejected in START
        c0 = cyc;
        ev_on[c0 + 3]  = 1'b1;
        ev_off[c0 + 7] = 1'b1;
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (12) tick();
        check("t5_status", in_status, 8'h00);
        check("t5_data", in_data, 8'h00);

        // push and rd_ack in the same cycle on an empty FIFO keeps the byte
        send_frame(8'h7E, 1'b1, 1'b1);
        check("t5b_status", in_status, 8'h11);
        check("t5b_data", in_data, 8'h7E);
        pulse_ack();

        // 6: full FIFO, rd_ack in the stop-sample cycle of the fifth byte
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        check("t6_full_status", in_status, 8'h41);
        check("t6_full_head", in_data, 8'h11);
        send_frame(8'h55, 1'b1, 1'b1);
        check("t6_swap_status", in_status, 8'h41);
        check("t6_swap_head", in_data, 8'h22);

        // async reset in the middle of a DATA phase
        c0 = cyc;
        ev_on[c0 + 3] = 1'b1;
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (12) tick();
        reset = 1'b0;
        model_clear();
        #1;
        check("t6_rst_data", in_data, 8'h00);
        check("t6_rst_status", in_status, 8'h00);
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t6_after_status", in_status, 8'h11);
        check("t6_after_data", in_data, 8'h5A);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
